// File: rtl/mem_boot_ctrl_if.sv
// Signal bundle between mem_boot_ctrl and its surroundings (host pins, CPU core, IMEM/DMEM).
// The master side is the environment; the slave side is the controller.
interface mem_boot_ctrl_if #(
    parameter int IMEM_AW = 7,
    parameter int DMEM_AW = 5
);
    logic               host_stb;
    logic [7:0]         host_byte;
    logic               host_cmd_stb;
    logic [1:0]         host_cmd;
    logic               cpu_rst_n;
    logic               cpu_en;
    logic [DMEM_AW-1:0] cpu_dmem_addr;
    logic [31:0]        cpu_dmem_wdata;
    logic               cpu_dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               dmem_we;
    logic [31:0]        dmem_rdata;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               imem_we;
    logic [7:0]         dout;
    logic               dout_valid;
    logic               dump_done;
    logic [1:0]         state;

    modport master (
        output host_stb, host_byte, host_cmd_stb, host_cmd,
        output cpu_dmem_addr, cpu_dmem_wdata, cpu_dmem_we, dmem_rdata,
        input  cpu_rst_n, cpu_en, dmem_addr, dmem_wdata, dmem_we,
        input  imem_addr, imem_wdata, imem_we, dout, dout_valid, dump_done, state
    );

    modport slave (
        input  host_stb, host_byte, host_cmd_stb, host_cmd,
        input  cpu_dmem_addr, cpu_dmem_wdata, cpu_dmem_we, dmem_rdata,
        output cpu_rst_n, cpu_en, dmem_addr, dmem_wdata, dmem_we,
        output imem_addr, imem_wdata, imem_we, dout, dout_valid, dump_done, state
    );
endinterface

// File: rtl/mem_boot_ctrl.sv
// Boot/run controller: loads IMEM from host bytes, runs/halts the CPU, and streams DMEM out.
// The DMEM port belongs to the CPU only in RUN; otherwise the dump engine owns the address.
module mem_boot_ctrl #(
    parameter int IMEM_AW    = 7,
    parameter int DMEM_AW    = 5,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_WORDS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_boot_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_DUMP = 2'b11
    } state_t;

    localparam logic [1:0]         CMD_LOAD = 2'b00;
    localparam logic [1:0]         CMD_RUN  = 2'b01;
    localparam logic [1:0]         CMD_HALT = 2'b10;
    localparam int                 WCW      = DMEM_AW + 1;
    localparam logic [DMEM_AW-1:0] BASE_A   = DMEM_AW'(DUMP_BASE);
    localparam logic [WCW-1:0]     LAST_W   = WCW'(DUMP_WORDS - 1);

    state_t             r_state;
    logic               r_stb_s1, r_stb_s2, r_stb_prev;
    logic               r_cmd_s1, r_cmd_s2, r_cmd_prev;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_word;
    logic [IMEM_AW-1:0] r_wptr;
    logic               r_cpu_rst_n, r_cpu_en;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic               r_imem_we;
    logic [DMEM_AW-1:0] r_dump_addr;
    logic [WCW-1:0]     r_dump_cnt;
    logic [2:0]         r_phase;
    logic [23:0]        r_rd;
    logic [7:0]         r_dout;
    logic               r_dout_valid;
    logic               r_dump_done;

    logic w_byte_ev, w_cmd_ev, w_abort, w_run;

    assign w_byte_ev = r_stb_s2 & ~r_stb_prev;
    assign w_cmd_ev  = r_cmd_s2 & ~r_cmd_prev;
    assign w_abort   = w_cmd_ev && (bus.host_cmd == CMD_HALT) && (r_state == S_DUMP);
    assign w_run     = (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_stb_s1, r_stb_s2, r_stb_prev} <= '0;
            {r_cmd_s1, r_cmd_s2, r_cmd_prev} <= '0;
        end else begin
            r_stb_s1   <= bus.host_stb;
            r_stb_s2   <= r_stb_s1;
            r_stb_prev <= r_stb_s2;
            r_cmd_s1   <= bus.host_cmd_stb;
            r_cmd_s2   <= r_cmd_s1;
            r_cmd_prev <= r_cmd_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_wptr       <= '0;
            r_cpu_rst_n  <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_imem_we    <= 1'b0;
            r_dump_addr  <= BASE_A;
            r_dump_cnt   <= '0;
            r_phase      <= '0;
            r_rd         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            r_imem_we   <= 1'b0;
            r_dump_done <= 1'b0;

            // A command event always takes precedence; a coincident byte is dropped.
            if (w_cmd_ev) begin
                case (bus.host_cmd)
                    CMD_LOAD: if (r_state == S_RUN || r_state == S_HALT) begin
                        r_state     <= S_LOAD;
                        r_wptr      <= '0;
                        r_byte_cnt  <= '0;
                        r_cpu_rst_n <= 1'b0;
                        r_cpu_en    <= 1'b0;
                    end
                    CMD_RUN: if (r_state == S_LOAD || r_state == S_HALT) begin
                        r_state     <= S_RUN;
                        r_byte_cnt  <= '0;
                        r_cpu_rst_n <= 1'b1;
                        r_cpu_en    <= 1'b1;
                    end
                    CMD_HALT: if (r_state == S_RUN) begin
                        r_state  <= S_HALT;
                        r_cpu_en <= 1'b0;
                    end else if (r_state == S_DUMP) begin
                        r_state      <= S_HALT;
                        r_dout_valid <= 1'b0;
                    end
                    default: if (r_state == S_RUN || r_state == S_HALT) begin
                        r_state     <= S_DUMP;
                        r_cpu_en    <= 1'b0;
                        r_dump_addr <= BASE_A;
                        r_dump_cnt  <= '0;
                        r_phase     <= '0;
                    end
                endcase
            end else if (w_byte_ev && r_state == S_LOAD) begin
                case (r_byte_cnt)
                    2'd0: r_word[7:0]   <= bus.host_byte;
                    2'd1: r_word[15:8]  <= bus.host_byte;
                    2'd2: r_word[23:16] <= bus.host_byte;
                    default: begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_wptr;
                        r_imem_wdata <= {bus.host_byte, r_word};
                        r_wptr       <= r_wptr + 1'b1;
                    end
                endcase
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            // Per word: address, capture, then four byte cycles LSB first.
            if (r_state == S_DUMP && !w_abort) begin
                case (r_phase)
                    3'd0: r_phase <= 3'd1;
                    3'd1: begin
                        r_rd         <= bus.dmem_rdata[31:8];
                        r_dout       <= bus.dmem_rdata[7:0];
                        r_dout_valid <= 1'b1;
                        r_phase      <= 3'd2;
                    end
                    3'd2: begin r_dout <= r_rd[7:0];   r_phase <= 3'd3; end
                    3'd3: begin r_dout <= r_rd[15:8];  r_phase <= 3'd4; end
                    3'd4: begin r_dout <= r_rd[23:16]; r_phase <= 3'd5; end
                    default: begin
                        r_dout_valid <= 1'b0;
                        r_dump_addr  <= r_dump_addr + 1'b1;
                        r_dump_cnt   <= r_dump_cnt + 1'b1;
                        r_phase      <= 3'd0;
                        if (r_dump_cnt == LAST_W) begin
                            r_dump_done <= 1'b1;
                            r_state     <= S_HALT;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.cpu_rst_n  = r_cpu_rst_n;
    assign bus.cpu_en     = r_cpu_en;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.imem_we    = r_imem_we;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dump_done  = r_dump_done;
    assign bus.dmem_we    = w_run & bus.cpu_dmem_we;
    assign bus.dmem_wdata = w_run ? bus.cpu_dmem_wdata : 32'd0;
    assign bus.dmem_addr  = w_run ? bus.cpu_dmem_addr : r_dump_addr;
endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Bench for mem_boot_ctrl: random host traffic against a queue-based model of the load/run/dump rules.
// A small synchronous-read DMEM lives here; monitors record IMEM writes and dumped bytes.
module tb_mem_boot_ctrl;
    localparam int IMEM_AW = 7, DMEM_AW = 5, DUMP_BASE = 0, DUMP_WORDS = 2;
    localparam logic [1:0] C_LOAD = 2'd0, C_RUN = 2'd1, C_HALT = 2'd2, C_DUMP = 2'd3;
    localparam int RV_W = 2 + 3 + IMEM_AW + 32 + 8 + 2 + 1 + 32 + DMEM_AW;

    typedef struct packed {
        logic [1:0]         st;
        logic [IMEM_AW-1:0] a;
        logic [31:0]        d;
    } iw_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0, bad = 0;

    mem_boot_ctrl_if #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) bus ();

    mem_boot_ctrl #(
        .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .DUMP_BASE(DUMP_BASE), .DUMP_WORDS(DUMP_WORDS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1<<DMEM_AW];
    always @(posedge clk) begin
        if (bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
        bus.dmem_rdata <= mem[bus.dmem_addr];
    end

    iw_t        act_w[$];
    logic [7:0] act_b[$];
    int         act_c[$];
    int         done_cnt, we_viol, cyc;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.imem_we) act_w.push_back(iw_t'({bus.state, bus.imem_addr, bus.imem_wdata}));
        if (bus.dout_valid) begin act_b.push_back(bus.dout); act_c.push_back(cyc); end
        if (bus.dump_done) done_cnt++;
        if (bus.dmem_we && bus.state != C_RUN) we_viol++;
    end

    // Reference model
    logic [1:0]  m_state;
    int          m_ptr;
    logic [7:0]  m_bytes[$];
    iw_t         exp_w[$];
    logic [31:0] exp_mem [1<<DMEM_AW];

    function automatic void model_byte(logic [7:0] b);
        if (m_state != C_LOAD) return;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            exp_w.push_back(iw_t'({C_LOAD, IMEM_AW'(m_ptr), m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]}));
            m_ptr = (m_ptr + 1) % (1 << IMEM_AW);
            m_bytes.delete();
        end
    endfunction

    function automatic void model_cmd(logic [1:0] c);
        case (c)
            C_LOAD: if (m_state == C_RUN || m_state == C_HALT) begin
                m_state = C_LOAD; m_ptr = 0; m_bytes.delete();
            end
            C_RUN: if (m_state == C_LOAD || m_state == C_HALT) begin
                m_state = C_RUN; m_bytes.delete();
            end
            C_HALT: if (m_state == C_RUN || m_state == C_DUMP) m_state = C_HALT;
            default: if (m_state == C_RUN || m_state == C_HALT) m_state = C_DUMP;
        endcase
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(logic [7:0] b);
        bus.host_byte = b; bus.host_stb = 1'b1;
        tick(4);
        bus.host_stb = 1'b0;
        tick(3);
        model_byte(b);
    endtask

    task automatic send_cmd(logic [1:0] c);
        bus.host_cmd = c; bus.host_cmd_stb = 1'b1;
        tick(4);
        bus.host_cmd_stb = 1'b0;
        tick(3);
        model_cmd(c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.host_stb = 1'b0; bus.host_cmd_stb = 1'b0;
        bus.cpu_dmem_we = 1'b0; bus.cpu_dmem_addr = '0; bus.cpu_dmem_wdata = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        m_state = C_LOAD; m_ptr = 0; m_bytes.delete();
    endtask

    task automatic test_reset();
        logic [RV_W-1:0] obs, exp_v;
        rst_n = 1'b1; bus.host_byte = '0; bus.host_cmd = '0;
        #1;
        do_reset();
        exp_v = '0; exp_v[DMEM_AW-1:0] = DMEM_AW'(DUMP_BASE);
        obs = {bus.state, bus.cpu_rst_n, bus.cpu_en, bus.imem_we, bus.imem_addr, bus.imem_wdata,
               bus.dout, 1'b0, bus.dout_valid, bus.dump_done, bus.dmem_wdata, bus.dmem_addr};
        total++; if (obs !== exp_v) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp_v); end
        total++; if (bus.dmem_we !== 1'b0) begin bad++; $display("FAIL reset_dmem_we got=%b exp=0", bus.dmem_we); end
    endtask

    task automatic test_load_basic();
        int a0, w0;
        a0 = act_w.size(); w0 = exp_w.size();
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
        total++; if (act_w.size() - a0 !== 1) begin bad++; $display("FAIL load_first_pulses got=%0d exp=1", act_w.size() - a0); end
        else begin
            total++;
            if (act_w[a0] !== iw_t'({C_LOAD, 7'd0, 32'h00100513})) begin
                bad++; $display("FAIL load_first_word got=%h exp=%h", act_w[a0], iw_t'({C_LOAD, 7'd0, 32'h00100513}));
            end
        end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        total++; if (act_w.size() - a0 !== exp_w.size() - w0) begin
            bad++; $display("FAIL load_count got=%0d exp=%0d", act_w.size() - a0, exp_w.size() - w0);
        end else for (int i = 0; i < exp_w.size() - w0; i++) begin
            total++; if (act_w[a0+i] !== exp_w[w0+i]) begin bad++; $display("FAIL load_word%0d got=%h exp=%h", i, act_w[a0+i], exp_w[w0+i]); end
        end
        total++; if (bus.cpu_rst_n !== 1'b0) begin bad++; $display("FAIL load_cpu_rst got=%b exp=0", bus.cpu_rst_n); end
    endtask

    task automatic test_partial_discard();
        int a0, w0;
        do_reset();
        a0 = act_w.size(); w0 = exp_w.size();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        send_cmd(C_RUN);
        total++; if ({bus.state, bus.cpu_rst_n, bus.cpu_en} !== {C_RUN, 2'b11}) begin
            bad++; $display("FAIL run_outputs got=%b exp=%b", {bus.state, bus.cpu_rst_n, bus.cpu_en}, {C_RUN, 2'b11});
        end
        send_cmd(C_HALT);
        total++; if ({bus.state, bus.cpu_rst_n, bus.cpu_en} !== {C_HALT, 2'b10}) begin
            bad++; $display("FAIL halt_outputs got=%b exp=%b", {bus.state, bus.cpu_rst_n, bus.cpu_en}, {C_HALT, 2'b10});
        end
        send_cmd(C_LOAD);
        total++; if ({bus.state, bus.cpu_rst_n, bus.cpu_en} !== {C_LOAD, 2'b00}) begin
            bad++; $display("FAIL reload_outputs got=%b exp=%b", {bus.state, bus.cpu_rst_n, bus.cpu_en}, {C_LOAD, 2'b00});
        end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        total++; if (act_w.size() - a0 !== 1) begin bad++; $display("FAIL partial_pulses got=%0d exp=1", act_w.size() - a0); end
        else begin
            total++;
            if (act_w[a0] !== iw_t'({C_LOAD, 7'd0, 32'hDDCCBBAA})) begin
                bad++; $display("FAIL partial_word got=%h exp=%h", act_w[a0], iw_t'({C_LOAD, 7'd0, 32'hDDCCBBAA}));
            end
            total++; if (act_w[a0] !== exp_w[w0]) begin bad++; $display("FAIL partial_model got=%h exp=%h", act_w[a0], exp_w[w0]); end
        end
    endtask

    task automatic test_wrap();
        int a0, w0, n;
        do_reset();
        a0 = act_w.size(); w0 = exp_w.size();
        for (int i = 0; i < 4 * ((1 << IMEM_AW) + 1); i++) send_byte(8'($urandom));
        n = act_w.size() - a0;
        total++; if (n !== exp_w.size() - w0) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", n, exp_w.size() - w0); end
        else begin
            for (int i = 0; i < n; i++) begin
                total++; if (act_w[a0+i] !== exp_w[w0+i]) begin bad++; $display("FAIL wrap_word%0d got=%h exp=%h", i, act_w[a0+i], exp_w[w0+i]); end
            end
            total++; if (act_w[a0+n-1].a !== 7'd0) begin bad++; $display("FAIL wrap_addr got=%0d exp=0", act_w[a0+n-1].a); end
        end
    endtask

    task automatic test_passthru();
        int v0;
        v0 = we_viol;
        send_cmd(C_RUN);
        for (int i = 0; i < 5; i++) begin
            bus.cpu_dmem_we    = (i == 0) ? 1'b1 : 1'($urandom);
            bus.cpu_dmem_addr  = (i == 0) ? DMEM_AW'(3) : DMEM_AW'($urandom);
            bus.cpu_dmem_wdata = (i == 0) ? 32'h12345678 : $urandom;
            #1;
            total++; if ({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== {bus.cpu_dmem_we, bus.cpu_dmem_addr, bus.cpu_dmem_wdata}) begin
                bad++; $display("FAIL passthru%0d got=%h exp=%h", i, {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata},
                                {bus.cpu_dmem_we, bus.cpu_dmem_addr, bus.cpu_dmem_wdata});
            end
            if (bus.cpu_dmem_we) exp_mem[bus.cpu_dmem_addr] = bus.cpu_dmem_wdata;
            tick(1);
        end
        bus.cpu_dmem_we = 1'b1; bus.cpu_dmem_addr = DMEM_AW'(3); bus.cpu_dmem_wdata = 32'h12345678;
        exp_mem[3] = 32'h12345678;
        send_cmd(C_HALT);
        bus.cpu_dmem_addr = '0; bus.cpu_dmem_wdata = 32'hDEADBEEF;
        #1;
        total++; if ({bus.dmem_we, bus.dmem_wdata, bus.cpu_en, bus.cpu_rst_n} !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL halt_block got=%h exp=%h", {bus.dmem_we, bus.dmem_wdata, bus.cpu_en, bus.cpu_rst_n}, {1'b0, 32'd0, 1'b0, 1'b1});
        end
        tick(3);
        bus.cpu_dmem_we = 1'b0;
        total++; if (we_viol !== v0) begin bad++; $display("FAIL halt_write_leak got=%0d exp=%0d", we_viol, v0); end
    endtask

    task automatic test_dump();
        int b0, d0;
        logic [31:0] wv;
        logic [7:0]  eb;
        for (int it = 0; it < 2; it++) begin
            send_cmd(C_RUN);
            for (int w = 0; w < DUMP_WORDS; w++) begin
                bus.cpu_dmem_we = 1'b1;
                bus.cpu_dmem_addr = DMEM_AW'(DUMP_BASE + w);
                bus.cpu_dmem_wdata = (it == 0) ? ((w == 0) ? 32'h04030201 : 32'h08070605) : $urandom;
                exp_mem[DMEM_AW'(DUMP_BASE + w)] = bus.cpu_dmem_wdata;
                tick(1);
            end
            bus.cpu_dmem_we = 1'b0;
            send_cmd(C_HALT);
            b0 = act_b.size(); d0 = done_cnt;
            send_cmd(C_DUMP);
            for (int k = 0; k < 60 && done_cnt == d0; k++) tick(1);
            tick(3);
            m_state = C_HALT;
            total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL dump%0d_done got=%0d exp=1", it, done_cnt - d0); end
            total++; if (bus.state !== C_HALT) begin bad++; $display("FAIL dump%0d_state got=%0d exp=2", it, bus.state); end
            total++; if (act_b.size() - b0 !== 4 * DUMP_WORDS) begin
                bad++; $display("FAIL dump%0d_bytes got=%0d exp=%0d", it, act_b.size() - b0, 4 * DUMP_WORDS);
            end else begin
                for (int k = 0; k < 4 * DUMP_WORDS; k++) begin
                    wv = exp_mem[(DUMP_BASE + k / 4) % (1 << DMEM_AW)];
                    eb = wv[8 * (k % 4) +: 8];
                    total++; if (act_b[b0+k] !== eb) begin bad++; $display("FAIL dump%0d_byte%0d got=%h exp=%h", it, k, act_b[b0+k], eb); end
                    total++; if (act_c[b0+k] - act_c[b0] !== (k / 4) * 6 + k % 4) begin
                        bad++; $display("FAIL dump%0d_slot%0d got=%0d exp=%0d", it, k, act_c[b0+k] - act_c[b0], (k / 4) * 6 + k % 4);
                    end
                end
                total++; if ({bus.dout_valid, bus.dout} !== {1'b0, eb}) begin
                    bad++; $display("FAIL dump%0d_hold got=%h exp=%h", it, {bus.dout_valid, bus.dout}, {1'b0, eb});
                end
            end
        end
    endtask

    task automatic test_abort();
        int b0, d0;
        b0 = act_b.size(); d0 = done_cnt;
        send_cmd(C_DUMP);
        for (int k = 0; k < 20 && bus.dout_valid !== 1'b0; k++) tick(1);
        for (int k = 0; k < 20 && bus.dout_valid !== 1'b1; k++) tick(1);
        bus.host_cmd = C_HALT; bus.host_cmd_stb = 1'b1;
        for (int k = 0; k < 10 && bus.state !== C_HALT; k++) tick(1);
        total++; if ({bus.state, bus.dout_valid} !== {C_HALT, 1'b0}) begin
            bad++; $display("FAIL abort_valid got=%b exp=%b", {bus.state, bus.dout_valid}, {C_HALT, 1'b0});
        end
        bus.host_cmd_stb = 1'b0;
        tick(15);
        m_state = C_HALT;
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_done got=%0d exp=%0d", done_cnt - d0, 0); end
        total++; if (act_b.size() - b0 !== 7) begin bad++; $display("FAIL abort_bytes got=%0d exp=7", act_b.size() - b0); end
        total++; if (bus.state !== C_HALT) begin bad++; $display("FAIL abort_state got=%0d exp=2", bus.state); end
    endtask

    task automatic test_simultaneous();
        int a0, w0;
        do_reset();
        a0 = act_w.size(); w0 = exp_w.size();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        bus.host_byte = 8'($urandom); bus.host_cmd = C_RUN;
        bus.host_stb = 1'b1; bus.host_cmd_stb = 1'b1;
        tick(4);
        bus.host_stb = 1'b0; bus.host_cmd_stb = 1'b0;
        tick(3);
        model_cmd(C_RUN);
        total++; if ({bus.state, act_w.size() - a0} !== {C_RUN, 32'd0}) begin
            bad++; $display("FAIL simul_run got=%0d/%0d exp=1/0", bus.state, act_w.size() - a0);
        end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        send_cmd(C_LOAD);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        total++; if (act_w.size() - a0 !== exp_w.size() - w0) begin
            bad++; $display("FAIL simul_count got=%0d exp=%0d", act_w.size() - a0, exp_w.size() - w0);
        end else for (int i = 0; i < exp_w.size() - w0; i++) begin
            total++; if (act_w[a0+i] !== exp_w[w0+i]) begin bad++; $display("FAIL simul_word%0d got=%h exp=%h", i, act_w[a0+i], exp_w[w0+i]); end
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [RV_W-1:0] obs, exp_v;
        send_cmd(C_RUN); send_cmd(C_HALT); send_cmd(C_DUMP);
        for (int k = 0; k < 20 && bus.dout_valid !== 1'b1; k++) tick(1);
        #1 rst_n = 1'b0;
        #1;
        exp_v = '0; exp_v[DMEM_AW-1:0] = DMEM_AW'(DUMP_BASE);
        obs = {bus.state, bus.cpu_rst_n, bus.cpu_en, bus.imem_we, bus.imem_addr, bus.imem_wdata,
               bus.dout, 1'b0, bus.dout_valid, bus.dump_done, bus.dmem_wdata, bus.dmem_addr};
        total++; if (obs !== exp_v) begin bad++; $display("FAIL midreset_outputs got=%h exp=%h", obs, exp_v); end
        tick(2);
        do_reset();
    endtask

    task automatic test_random();
        int a0, w0;
        logic [1:0] c;
        do_reset();
        a0 = act_w.size(); w0 = exp_w.size();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 6) send_byte(8'($urandom));
            else begin c = 2'($urandom_range(0, 2)); send_cmd(c); end
            total++; if ({bus.state, bus.cpu_rst_n, bus.cpu_en} !== {m_state, m_state != C_LOAD, m_state == C_RUN}) begin
                bad++; $display("FAIL rand_state%0d got=%b exp=%b", i, {bus.state, bus.cpu_rst_n, bus.cpu_en},
                                {m_state, m_state != C_LOAD, m_state == C_RUN});
            end
        end
        total++; if (act_w.size() - a0 !== exp_w.size() - w0) begin
            bad++; $display("FAIL rand_count got=%0d exp=%0d", act_w.size() - a0, exp_w.size() - w0);
        end else for (int i = 0; i < exp_w.size() - w0; i++) begin
            total++; if (act_w[a0+i] !== exp_w[w0+i]) begin bad++; $display("FAIL rand_word%0d got=%h exp=%h", i, act_w[a0+i], exp_w[w0+i]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_partial_discard();
        test_wrap();
        test_passthru();
        test_dump();
        test_abort();
        test_simultaneous();
        test_reset_mid_dump();
        test_random();
        total++; if (we_viol !== 0) begin bad++; $display("FAIL dmem_we_outside_run got=%0d exp=0", we_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
